// File: rtl/apb_biu_mslv.sv
// CPU load/store to APB4 master bridge: one outstanding transfer, byte/half/word lanes, slave decode, error codes.
// Define APB_BIU_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYC cycles without PREADY.
module apb_biu_mslv #(
  parameter int ADDR_W      = 32,
  parameter int NUM_SLV     = 3,
  parameter int SEL_LSB     = 12,
  parameter int SEL_W       = 2,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req,
  input  logic                  i_we,
  input  logic [2:0]            i_funct3,
  input  logic [ADDR_W-1:0]     i_addr,
  input  logic [31:0]           i_wdata,
  output logic                  o_ready,
  output logic                  o_done,
  output logic                  o_err,
  output logic [1:0]            o_err_code,
  output logic [31:0]           o_ld_data,
  output logic [ADDR_W-1:0]     o_paddr,
  output logic [NUM_SLV-1:0]    o_psel,
  output logic                  o_penable,
  output logic                  o_pwrite,
  output logic [31:0]           o_pwdata,
  output logic [3:0]            o_pstrb,
  input  logic [NUM_SLV*32-1:0] i_prdata,
  input  logic [NUM_SLV-1:0]    i_pready,
  input  logic [NUM_SLV-1:0]    i_pslverr
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_DONE} state_t;

  state_t           state;
  logic [2:0]       r_funct3;
  logic [1:0]       r_lane;
  logic [SEL_W-1:0] r_idx;

  logic [SEL_W-1:0]   req_idx;
  logic               req_illegal, req_misalign, req_dec_fail;
  logic [NUM_SLV-1:0] req_sel;
  logic [31:0]        req_wdata;
  logic [3:0]         req_strb;

  // Request classification straight from the CPU inputs, used only on the accept edge
  always_comb begin
    req_idx      = i_addr[SEL_LSB +: SEL_W];
    req_dec_fail = ({1'b0, req_idx} >= (SEL_W+1)'(NUM_SLV));
    req_sel      = '0;
    if (!req_dec_fail) req_sel[req_idx] = 1'b1;
    if (i_we) req_illegal = i_funct3[2] | (i_funct3[1:0] == 2'b11);
    else      req_illegal = (i_funct3 == 3'b011) | (i_funct3[2:1] == 2'b11);
    case (i_funct3[1:0])
      2'b01:   req_misalign = i_addr[0];
      2'b10:   req_misalign = |i_addr[1:0];
      default: req_misalign = 1'b0;
    endcase
    case (i_funct3[1:0])
      2'b00: begin
        req_wdata = {24'b0, i_wdata[7:0]} << {i_addr[1:0], 3'b000};
        req_strb  = 4'b0001 << i_addr[1:0];
      end
      2'b01: begin
        req_wdata = {16'b0, i_wdata[15:0]} << {i_addr[1], 4'b0000};
        req_strb  = 4'b0011 << {i_addr[1], 1'b0};
      end
      default: begin
        req_wdata = i_wdata;
        req_strb  = 4'b1111;
      end
    endcase
  end

  logic [31:0] prd, prd_sh, ld_ext;
  logic        cur_ready, cur_err;

  always_comb begin
    prd       = i_prdata[{r_idx, 5'b00000} +: 32];
    prd_sh    = prd >> {r_lane, 3'b000};
    cur_ready = i_pready[r_idx];
    cur_err   = i_pslverr[r_idx];
    case (r_funct3)
      3'b000:  ld_ext = {{24{prd_sh[7]}}, prd_sh[7:0]};
      3'b100:  ld_ext = {24'b0, prd_sh[7:0]};
      3'b001:  ld_ext = {{16{prd_sh[15]}}, prd_sh[15:0]};
      3'b101:  ld_ext = {16'b0, prd_sh[15:0]};
      default: ld_ext = prd;
    endcase
  end

`ifdef APB_BIU_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_cnt;
`endif

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state      <= S_IDLE;
      r_funct3   <= '0;
      r_lane     <= '0;
      r_idx      <= '0;
      o_ready    <= 1'b1;
      o_done     <= 1'b0;
      o_err      <= 1'b0;
      o_err_code <= '0;
      o_ld_data  <= '0;
      o_paddr    <= '0;
      o_psel     <= '0;
      o_penable  <= 1'b0;
      o_pwrite   <= 1'b0;
      o_pwdata   <= '0;
      o_pstrb    <= '0;
`ifdef APB_BIU_TIMEOUT_EN
      tmo_cnt    <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: if (i_req) begin
          r_funct3 <= i_funct3;
          r_lane   <= i_addr[1:0];
          r_idx    <= req_idx;
          o_ready  <= 1'b0;
          if (req_illegal || req_misalign) begin
            state      <= S_DONE;
            o_done     <= 1'b1;
            o_err      <= 1'b1;
            o_err_code <= 2'b10;
          end else if (req_dec_fail) begin
            state      <= S_DONE;
            o_done     <= 1'b1;
            o_err      <= 1'b1;
            o_err_code <= 2'b11;
          end else begin
            state    <= S_SETUP;
            o_psel   <= req_sel;
            o_paddr  <= {i_addr[ADDR_W-1:2], 2'b00};
            o_pwrite <= i_we;
            o_pwdata <= i_we ? req_wdata : 32'b0;
            o_pstrb  <= i_we ? req_strb : 4'b0;
          end
        end
        S_SETUP: begin
          state     <= S_ACCESS;
          o_penable <= 1'b1;
`ifdef APB_BIU_TIMEOUT_EN
          tmo_cnt   <= '0;
`endif
        end
        S_ACCESS: begin
          if (cur_ready) begin
            state     <= S_DONE;
            o_psel    <= '0;
            o_penable <= 1'b0;
            o_done    <= 1'b1;
            if (cur_err) begin
              o_err      <= 1'b1;
              o_err_code <= 2'b01;
            end else if (!o_pwrite) begin
              o_ld_data <= ld_ext;
            end
          end
`ifdef APB_BIU_TIMEOUT_EN
          else if (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)) begin
            state      <= S_DONE;
            o_psel     <= '0;
            o_penable  <= 1'b0;
            o_done     <= 1'b1;
            o_err      <= 1'b1;
            o_err_code <= 2'b11;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        default: begin
          state      <= S_IDLE;
          o_ready    <= 1'b1;
          o_done     <= 1'b0;
          o_err      <= 1'b0;
          o_err_code <= '0;
          o_ld_data  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_biu_mslv.sv
// Directed bench for apb_biu_mslv: scoreboard of expected completions, immediate-assertion checks.
`timescale 1ns/1ps
module tb_apb_biu_mslv;
  localparam int NS = 3;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b0;
  logic          i_req, i_we;
  logic [2:0]    i_funct3;
  logic [31:0]   i_addr, i_wdata;
  logic          o_ready, o_done, o_err, o_penable, o_pwrite;
  logic [1:0]    o_err_code;
  logic [31:0]   o_ld_data, o_paddr, o_pwdata;
  logic [NS-1:0] o_psel;
  logic [3:0]    o_pstrb;
  logic [NS*32-1:0] i_prdata;
  logic [NS-1:0] i_pready, i_pslverr;

  apb_biu_mslv dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .i_we(i_we), .i_funct3(i_funct3),
    .i_addr(i_addr), .i_wdata(i_wdata), .o_ready(o_ready), .o_done(o_done), .o_err(o_err),
    .o_err_code(o_err_code), .o_ld_data(o_ld_data), .o_paddr(o_paddr), .o_psel(o_psel),
    .o_penable(o_penable), .o_pwrite(o_pwrite), .o_pwdata(o_pwdata), .o_pstrb(o_pstrb),
    .i_prdata(i_prdata), .i_pready(i_pready), .i_pslverr(i_pslverr)
  );

  always #5 i_clk = ~i_clk;

  // Slave model: target slave answers after `waits` ACCESS cycles; the others look ready/erroring to expose bad muxing
  int          tgt = 0, waits = 0, acc_cnt = 0;
  logic [31:0] rdata = 32'h0;
  logic        serr = 1'b0;

  always @(posedge i_clk or negedge i_rst)
    if (!i_rst) acc_cnt <= 0;
    else if (o_penable && (o_psel != '0)) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;

  always_comb begin
    i_prdata  = '0;
    i_pready  = '0;
    i_pslverr = '0;
    for (int k = 0; k < NS; k++) begin
      if (k == tgt) begin
        i_prdata[32*k +: 32] = rdata;
        i_pready[k]          = (acc_cnt >= waits);
        i_pslverr[k]         = serr;
      end else begin
        i_prdata[32*k +: 32] = 32'h5A5A_5A5A ^ k;
        i_pready[k]          = 1'b1;
        i_pslverr[k]         = 1'b1;
      end
    end
  end

  typedef struct {
    logic        err;
    logic [1:0]  code;
    logic [31:0] ld;
    int          lat;
    logic [2:0]  psel;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic err, input logic [1:0] code, input logic [31:0] ld, input int lat,
                              input logic [2:0] psel, input logic [31:0] paddr, input logic [31:0] pwdata,
                              input logic [3:0] pstrb);
    exp_t e;
    e.err = err; e.code = code; e.ld = ld; e.lat = lat;
    e.psel = psel; e.paddr = paddr; e.pwdata = pwdata; e.pstrb = pstrb;
    return e;
  endfunction

  task automatic xfer(input string tag, input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wdata, input exp_t e, input bit poke);
    exp_t        x;
    int          n, setup_cnt, leak;
    logic [2:0]  psel_or;
    logic [31:0] s_paddr, s_pwdata;
    logic [3:0]  s_pstrb;
    logic        seen_done;
    sb.push_back(e);
    @(negedge i_clk);
    chk({tag, " ready"}, {31'b0, o_ready}, 32'd1);
    i_req = 1'b1; i_we = we; i_funct3 = f3; i_addr = addr; i_wdata = wdata;
    @(negedge i_clk);
    i_req = 1'b0; i_we = 1'b0; i_funct3 = 3'b0; i_addr = 32'h0; i_wdata = 32'h0;
    n = 1; setup_cnt = 0; leak = 0; psel_or = '0; seen_done = 1'b0;
    s_paddr = 32'h0; s_pwdata = 32'h0; s_pstrb = 4'h0;
    while (n <= 60) begin
      if (o_psel != '0) begin
        psel_or |= o_psel;
        if (!o_penable) begin
          setup_cnt++;
          s_paddr = o_paddr; s_pwdata = o_pwdata; s_pstrb = o_pstrb;
        end
      end
      if (!o_done && (o_err || o_err_code != 2'b00 || o_ld_data != 32'h0)) leak++;
      if (poke && n == 2) begin
        i_req = 1'b1; i_we = 1'b1; i_funct3 = 3'b010; i_addr = 32'h0000_2000; i_wdata = 32'h1111_2222;
      end
      if (poke && n == 3) begin
        i_req = 1'b0; i_we = 1'b0; i_funct3 = 3'b0; i_addr = 32'h0; i_wdata = 32'h0;
      end
      if (o_done) begin
        seen_done = 1'b1;
        break;
      end
      @(negedge i_clk);
      n++;
    end
    x = sb.pop_front();
    chk({tag, " done"}, {31'b0, seen_done}, 32'd1);
    chk({tag, " latency"}, n, x.lat);
    chk({tag, " err"}, {31'b0, o_err}, {31'b0, x.err});
    chk({tag, " code"}, {30'b0, o_err_code}, {30'b0, x.code});
    chk({tag, " ld_data"}, o_ld_data, x.ld);
    chk({tag, " psel"}, {29'b0, psel_or}, {29'b0, x.psel});
    chk({tag, " setup_cycles"}, setup_cnt, (x.psel != 3'b0) ? 1 : 0);
    chk({tag, " idle_outputs_zero"}, leak, 0);
    if (x.psel != 3'b0) begin
      chk({tag, " paddr"}, s_paddr, x.paddr);
      chk({tag, " pstrb"}, {28'b0, s_pstrb}, {28'b0, x.pstrb});
      if (x.pstrb != 4'h0) chk({tag, " pwdata"}, s_pwdata, x.pwdata);
    end
  endtask

  initial begin
    int quiet;
    i_req = 1'b0; i_we = 1'b0; i_funct3 = 3'b0; i_addr = 32'h0; i_wdata = 32'h0;
    repeat (3) @(negedge i_clk);
    chk("rst ready", {31'b0, o_ready}, 32'd1);
    chk("rst done", {31'b0, o_done}, 32'd0);
    chk("rst psel", {29'b0, o_psel}, 32'd0);
    chk("rst paddr", o_paddr, 32'd0);
    i_rst = 1'b1;

    tgt = 2; waits = 0;
    xfer("sw_slv2", 1'b1, 3'b010, 32'h0000_2004, 32'hDEAD_BEEF,
         mk(1'b0, 2'b00, 32'h0, 3, 3'b100, 32'h0000_2004, 32'hDEAD_BEEF, 4'b1111), 1'b0);
    tgt = 1; waits = 2; rdata = 32'h80AA_5511;
    xfer("lb_wait2", 1'b0, 3'b000, 32'h0000_1003, 32'h0,
         mk(1'b0, 2'b00, 32'hFFFF_FF80, 5, 3'b010, 32'h0000_1000, 32'h0, 4'b0000), 1'b0);
    waits = 0;
    xfer("lbu", 1'b0, 3'b100, 32'h0000_1003, 32'h0,
         mk(1'b0, 2'b00, 32'h0000_0080, 3, 3'b010, 32'h0000_1000, 32'h0, 4'b0000), 1'b0);
    xfer("lh_hi", 1'b0, 3'b001, 32'h0000_1002, 32'h0,
         mk(1'b0, 2'b00, 32'hFFFF_80AA, 3, 3'b010, 32'h0000_1000, 32'h0, 4'b0000), 1'b0);
    rdata = 32'h1234_5678;
    xfer("lw", 1'b0, 3'b010, 32'h0000_1008, 32'h0,
         mk(1'b0, 2'b00, 32'h1234_5678, 3, 3'b010, 32'h0000_1008, 32'h0, 4'b0000), 1'b0);
    tgt = 0;
    xfer("sb_lane2", 1'b1, 3'b000, 32'h0000_0002, 32'h0000_00A5,
         mk(1'b0, 2'b00, 32'h0, 3, 3'b001, 32'h0000_0000, 32'h00A5_0000, 4'b0100), 1'b0);
    rdata = 32'h00A5_0000;
    xfer("lhu", 1'b0, 3'b101, 32'h0000_0002, 32'h0,
         mk(1'b0, 2'b00, 32'h0000_00A5, 3, 3'b001, 32'h0000_0000, 32'h0, 4'b0000), 1'b0);
    xfer("sh_hi", 1'b1, 3'b001, 32'h0000_0002, 32'hFFFF_1234,
         mk(1'b0, 2'b00, 32'h0, 3, 3'b001, 32'h0000_0000, 32'h1234_0000, 4'b1100), 1'b0);

    xfer("lw_misalign", 1'b0, 3'b010, 32'h0000_0006, 32'h0,
         mk(1'b1, 2'b10, 32'h0, 1, 3'b000, 32'h0, 32'h0, 4'h0), 1'b0);
    xfer("sw_decode", 1'b1, 3'b010, 32'h0000_3000, 32'h1,
         mk(1'b1, 2'b11, 32'h0, 1, 3'b000, 32'h0, 32'h0, 4'h0), 1'b0);
    xfer("ld_illegal", 1'b0, 3'b011, 32'h0000_0000, 32'h0,
         mk(1'b1, 2'b10, 32'h0, 1, 3'b000, 32'h0, 32'h0, 4'h0), 1'b0);
    xfer("st_illegal_over_decode", 1'b1, 3'b100, 32'h0000_3000, 32'h0,
         mk(1'b1, 2'b10, 32'h0, 1, 3'b000, 32'h0, 32'h0, 4'h0), 1'b0);
    xfer("lh_misalign_over_decode", 1'b0, 3'b001, 32'h0000_3001, 32'h0,
         mk(1'b1, 2'b10, 32'h0, 1, 3'b000, 32'h0, 32'h0, 4'h0), 1'b0);

    tgt = 0; serr = 1'b1; rdata = 32'hFFFF_FFFF;
    xfer("lw_pslverr", 1'b0, 3'b010, 32'h0000_0010, 32'h0,
         mk(1'b1, 2'b01, 32'h0, 3, 3'b001, 32'h0000_0010, 32'h0, 4'b0000), 1'b0);
    serr = 1'b0;

`ifdef APB_BIU_TIMEOUT_EN
    tgt = 2; waits = 1000; rdata = 32'hCAFE_F00D;
    xfer("lw_timeout", 1'b0, 3'b010, 32'h0000_2000, 32'h0,
         mk(1'b1, 2'b11, 32'h0, 18, 3'b100, 32'h0000_2000, 32'h0, 4'b0000), 1'b0);
`else
    tgt = 2; waits = 20; rdata = 32'hCAFE_F00D;
    xfer("lw_long_wait", 1'b0, 3'b010, 32'h0000_2000, 32'h0,
         mk(1'b0, 2'b00, 32'hCAFE_F00D, 23, 3'b100, 32'h0000_2000, 32'h0, 4'b0000), 1'b0);
`endif

    // Request raised while busy must not start a second transfer
    tgt = 1; waits = 3; rdata = 32'h0BAD_F00D;
    xfer("lw_poke", 1'b0, 3'b010, 32'h0000_1004, 32'h0,
         mk(1'b0, 2'b00, 32'h0BAD_F00D, 6, 3'b010, 32'h0000_1004, 32'h0, 4'b0000), 1'b1);
    quiet = 0;
    repeat (6) begin
      @(negedge i_clk);
      if (o_psel != '0 || !o_ready) quiet++;
    end
    chk("poke not_reissued", quiet, 0);

    // Async reset in the middle of ACCESS
    tgt = 1; waits = 50;
    @(negedge i_clk);
    i_req = 1'b1; i_we = 1'b0; i_funct3 = 3'b010; i_addr = 32'h0000_1000;
    @(negedge i_clk);
    i_req = 1'b0; i_addr = 32'h0;
    quiet = 0;
    while (!o_penable && quiet < 10) begin
      @(negedge i_clk);
      quiet++;
    end
    chk("rst_mid reached_access", {31'b0, o_penable}, 32'd1);
    #2 i_rst = 1'b0;
    #1;
    chk("rst_mid psel", {29'b0, o_psel}, 32'd0);
    chk("rst_mid penable", {31'b0, o_penable}, 32'd0);
    @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    chk("rst_mid ready", {31'b0, o_ready}, 32'd1);
    chk("rst_mid done", {31'b0, o_done}, 32'd0);
    waits = 0; rdata = 32'h7654_3210;
    xfer("post_rst_lw", 1'b0, 3'b010, 32'h0000_100C, 32'h0,
         mk(1'b0, 2'b00, 32'h7654_3210, 3, 3'b010, 32'h0000_100C, 32'h0, 4'b0000), 1'b0);

    chk("scoreboard empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
